// File: rtl/eth_rx_frame_buf.sv
// eth_rx_frame_buf: receive frame buffer between eth_rx and packet logic.
// Bytes land in a circular RAM; each frame is filtered and checked, then committed
// (FCS trimmed) or rolled back. Committed frames are replayed on a valid/ready stream.
module eth_rx_frame_buf #(
   parameter int unsigned ADDR_W   = 12,
   parameter int unsigned LEN_AW   = 4,
   parameter logic [47:0] MAC_ADDR = 48'h000A35000001,
   parameter int unsigned MIN_LEN  = 64,
   parameter int unsigned MAX_LEN  = 1518
) (
   input  logic        clk_mac,
   input  logic        rst_n,
   input  logic        promisc,
   input  logic        rx_vld,
   input  logic [7:0]  rx_dat,
   input  logic        rx_sof,
   input  logic        rx_eof,
   input  logic        rx_err,
   output logic        m_vld,
   output logic [7:0]  m_dat,
   output logic        m_sof,
   output logic        m_eof,
   output logic [10:0] m_len,
   input  logic        m_rdy,
   output logic        drop_err,
   output logic        drop_len,
   output logic        drop_filt,
   output logic        drop_ovf
);

   localparam int unsigned PW        = ADDR_W + 1;
   localparam int unsigned RAM_DEPTH = 1 << ADDR_W;
   localparam int unsigned LF_PW     = LEN_AW + 1;
   localparam int unsigned LF_DEPTH  = 1 << LEN_AW;
   localparam int unsigned CW        = 11;
   localparam int unsigned FCS_LEN   = 4;

   typedef enum logic [1:0] {W_IDLE, W_RECV, W_DROP} wr_state_t;
   typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} rd_state_t;

   // Storage
   logic [7:0]       r_ram    [RAM_DEPTH];
   logic [CW-1:0]    r_lf_mem [LF_DEPTH];

   // Write side state
   wr_state_t        r_wr_state;
   logic [PW-1:0]    r_wr_ptr;
   logic [PW-1:0]    r_commit_ptr;
   logic [CW-1:0]    r_cnt;
   logic             r_own_match;
   logic             r_bc_match;
   logic [LF_PW-1:0] r_lf_wp;

   // Read side state
   rd_state_t        r_rd_state;
   logic [PW-1:0]    r_rd_ptr;
   logic [PW-1:0]    r_fetch_ptr;
   logic [LF_PW-1:0] r_lf_rp;
   logic [CW-1:0]    r_cur_len;
   logic [CW-1:0]    r_left;

   // Derived
   logic [PW-1:0]     w_used;
   logic              w_ram_full;
   logic              w_lf_full;
   logic              w_lf_empty;
   logic              w_data_beat;
   logic              w_eof_beat;
   logic              w_sof_beat;
   logic              w_filt_pass;
   logic              w_commit;
   logic              w_ram_we;
   logic [ADDR_W-1:0] w_ram_waddr;
   logic [7:0]        w_mac_exp;

   // Occupancy counts committed plus in-flight bytes against bytes still unread
   assign w_used      = r_wr_ptr - r_rd_ptr;
   assign w_ram_full  = (w_used == PW'(RAM_DEPTH));
   assign w_lf_full   = ((r_lf_wp - r_lf_rp) == LF_PW'(LF_DEPTH));
   assign w_lf_empty  = (r_lf_wp == r_lf_rp);

   // A beat with rx_eof carries no byte, and sof+eof together counts only as eof
   assign w_data_beat = rx_vld && !rx_eof;
   assign w_eof_beat  = rx_vld && rx_eof;
   assign w_sof_beat  = w_data_beat && rx_sof;

   assign w_filt_pass = promisc || r_own_match || r_bc_match;
   assign w_commit    = (r_wr_state == W_RECV) && w_eof_beat && !rx_err &&
                        (r_cnt >= CW'(MIN_LEN)) && w_filt_pass;

   // Expected station-address byte for the next incoming byte (bytes 2..6)
   always_comb begin
      w_mac_exp = MAC_ADDR[7:0];
      case (r_cnt)
         11'd1:   w_mac_exp = MAC_ADDR[39:32];
         11'd2:   w_mac_exp = MAC_ADDR[31:24];
         11'd3:   w_mac_exp = MAC_ADDR[23:16];
         11'd4:   w_mac_exp = MAC_ADDR[15:8];
         default: w_mac_exp = MAC_ADDR[7:0];
      endcase
   end

   // RAM write port decode; a restart rewrites from the rolled-back commit point
   always_comb begin
      w_ram_we    = 1'b0;
      w_ram_waddr = r_wr_ptr[ADDR_W-1:0];
      case (r_wr_state)
         W_IDLE: begin
            if (w_sof_beat && !w_lf_full && !w_ram_full) w_ram_we = 1'b1;
         end
         W_RECV: begin
            if (w_sof_beat) begin
               w_ram_we    = 1'b1;
               w_ram_waddr = r_commit_ptr[ADDR_W-1:0];
            end else if (w_data_beat && !w_ram_full && (r_cnt != CW'(MAX_LEN))) begin
               w_ram_we = 1'b1;
            end
         end
         default: ;
      endcase
   end

   // Frame byte RAM write
   always_ff @(posedge clk_mac) begin
      if (w_ram_we) r_ram[w_ram_waddr] <= rx_dat;
   end

   // Committed-frame length FIFO write (length excludes FCS)
   always_ff @(posedge clk_mac) begin
      if (w_commit) r_lf_mem[r_lf_wp[LEN_AW-1:0]] <= r_cnt - CW'(FCS_LEN);
   end

   // Write FSM: receive, filter, commit or roll back, one drop pulse per rejected frame
   always_ff @(posedge clk_mac or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_state   <= W_IDLE;
         r_wr_ptr     <= '0;
         r_commit_ptr <= '0;
         r_cnt        <= '0;
         r_own_match  <= 1'b0;
         r_bc_match   <= 1'b0;
         r_lf_wp      <= '0;
         drop_err     <= 1'b0;
         drop_len     <= 1'b0;
         drop_filt    <= 1'b0;
         drop_ovf     <= 1'b0;
      end else begin
         drop_err  <= 1'b0;
         drop_len  <= 1'b0;
         drop_filt <= 1'b0;
         drop_ovf  <= 1'b0;
         case (r_wr_state)
            W_IDLE: begin
               if (w_sof_beat) begin
                  if (w_lf_full || w_ram_full) begin
                     drop_ovf   <= 1'b1;
                     r_wr_state <= W_DROP;
                  end else begin
                     r_wr_ptr    <= r_wr_ptr + PW'(1);
                     r_cnt       <= CW'(1);
                     r_own_match <= (rx_dat == MAC_ADDR[47:40]);
                     r_bc_match  <= (rx_dat == 8'hFF);
                     r_wr_state  <= W_RECV;
                  end
               end
            end
            W_RECV: begin
               if (w_eof_beat) begin
                  r_wr_state <= W_IDLE;
                  if (w_commit) begin
                     r_commit_ptr <= r_wr_ptr - PW'(FCS_LEN);
                     r_wr_ptr     <= r_wr_ptr - PW'(FCS_LEN);
                     r_lf_wp      <= r_lf_wp + LF_PW'(1);
                  end else begin
                     r_wr_ptr <= r_commit_ptr;
                     if (rx_err)                     drop_err  <= 1'b1;
                     else if (r_cnt < CW'(MIN_LEN))  drop_len  <= 1'b1;
                     else                            drop_filt <= 1'b1;
                  end
               end else if (w_sof_beat) begin
                  // Open frame aborted by a new sof: drop it and restart at byte 1
                  drop_err    <= 1'b1;
                  r_wr_ptr    <= r_commit_ptr + PW'(1);
                  r_cnt       <= CW'(1);
                  r_own_match <= (rx_dat == MAC_ADDR[47:40]);
                  r_bc_match  <= (rx_dat == 8'hFF);
               end else if (w_data_beat) begin
                  if (w_ram_full) begin
                     drop_ovf   <= 1'b1;
                     r_wr_ptr   <= r_commit_ptr;
                     r_wr_state <= W_DROP;
                  end else if (r_cnt == CW'(MAX_LEN)) begin
                     drop_len   <= 1'b1;
                     r_wr_ptr   <= r_commit_ptr;
                     r_wr_state <= W_DROP;
                  end else begin
                     r_wr_ptr <= r_wr_ptr + PW'(1);
                     if (r_cnt != 11'h7FF) r_cnt <= r_cnt + CW'(1);
                     if (r_cnt < CW'(6)) begin
                        r_own_match <= r_own_match && (rx_dat == w_mac_exp);
                        r_bc_match  <= r_bc_match && (rx_dat == 8'hFF);
                     end
                  end
               end
            end
            W_DROP: begin
               if (w_eof_beat) r_wr_state <= W_IDLE;
            end
            default: r_wr_state <= W_IDLE;
         endcase
      end
   end

   // Read FSM: pop a length, present bytes with registered outputs held under backpressure
   always_ff @(posedge clk_mac or negedge rst_n) begin
      if (!rst_n) begin
         r_rd_state  <= R_IDLE;
         r_rd_ptr    <= '0;
         r_fetch_ptr <= '0;
         r_lf_rp     <= '0;
         r_cur_len   <= '0;
         r_left      <= '0;
         m_vld       <= 1'b0;
         m_dat       <= '0;
         m_sof       <= 1'b0;
         m_eof       <= 1'b0;
         m_len       <= '0;
      end else begin
         case (r_rd_state)
            R_IDLE: begin
               if (!w_lf_empty) begin
                  r_cur_len   <= r_lf_mem[r_lf_rp[LEN_AW-1:0]];
                  r_lf_rp     <= r_lf_rp + LF_PW'(1);
                  r_fetch_ptr <= r_rd_ptr;
                  r_rd_state  <= R_FETCH;
               end
            end
            R_FETCH: begin
               m_vld       <= 1'b1;
               m_dat       <= r_ram[r_fetch_ptr[ADDR_W-1:0]];
               m_sof       <= 1'b1;
               m_eof       <= (r_cur_len == CW'(1));
               m_len       <= r_cur_len;
               r_left      <= r_cur_len - CW'(1);
               r_fetch_ptr <= r_fetch_ptr + PW'(1);
               r_rd_state  <= R_DATA;
            end
            R_DATA: begin
               if (m_rdy) begin
                  // Each accepted byte frees its RAM slot for the writer
                  r_rd_ptr <= r_rd_ptr + PW'(1);
                  if (m_eof) begin
                     m_vld      <= 1'b0;
                     m_sof      <= 1'b0;
                     m_eof      <= 1'b0;
                     m_len      <= '0;
                     m_dat      <= '0;
                     r_rd_state <= R_IDLE;
                  end else begin
                     m_dat       <= r_ram[r_fetch_ptr[ADDR_W-1:0]];
                     m_sof       <= 1'b0;
                     m_eof       <= (r_left == CW'(1));
                     r_left      <= r_left - CW'(1);
                     r_fetch_ptr <= r_fetch_ptr + PW'(1);
                  end
               end
            end
            default: r_rd_state <= R_IDLE;
         endcase
      end
   end

endmodule
